ls_usb_tx: RTL
==============

# ls_usb_tx

Low-speed (1.5 Mbit/s) USB packet transmitter: the line-side back end of the device packet source. It pulls bytes from the source through the `sbyte`/`start_pkt`/`last_pkt_byte`/`show_next` handshake. The source supplies the sync byte, the PID and the payload. The block serializes each byte LSB first, inserts stuff bits, NRZI-encodes the stream, drives D+/D- and ends every packet with an EOP.

## Interface
- `CLK_DIV`, default 8: clocks per bit time (12 MHz clk gives 1.5 Mbit/s). Must be ≥ 4.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start_pkt` in 1: one-cycle pulse; `sbyte` holds byte 0 (sync 0x80) in this cycle.
- `sbyte` in 8: current byte from the source.
- `last_pkt_byte` in 1: `sbyte` is the final byte from the source.
- `show_next` out 1: registered one-cycle pulse telling the source to advance to the next byte.
- `dp` out 1: D+ level.
- `dm` out 1: D- level.
- `oe` out 1: transceiver drive enable.
- `busy` out 1: high from the cycle after `start_pkt` until `oe` drops.

## Operation
- **Reset values:** `dp`=0, `dm`=1 (idle J), `oe`=0, `show_next`=0, `busy`=0. State is IDLE and all counters are 0.
- **Line states:** J = (`dp`,`dm`) (0,1). K = (1,0). SE0 = (0,0).
- **States:**
  - IDLE: waiting for a packet.
  - DATA: shifting out bytes.
  - EOP0: SE0 for 2 bit times.
  - EOP1: J for 1 bit time.
  - Transitions: IDLE→DATA on `start_pkt`. DATA→EOP0 after the last bit, including any trailing stuff bit. EOP0→EOP1→IDLE.
- **Byte load:**
  - On load, `sbyte` is copied to an 8-bit shift register and `last_pkt_byte` to a last flag.
  - A byte is loaded on `start_pkt` and at the bit boundary that ends bit 7 of a non-last byte.
  - `show_next` pulses the cycle after each load whose last flag is 0. It never pulses for the last byte.
- **Bit timer:** counts 0..`CLK_DIV`-1. A bit boundary occurs when count = `CLK_DIV`-1.
- **NRZI:**
  - Data 0 toggles the line (J↔K). Data 1 holds it.
  - Line state before the first bit is J.
- **Bit stuffing:**
  - A ones counter (3 bits) increments on each transmitted 1 and clears on any 0, including a stuffed 0.
  - When it reaches 6, the next bit slot is a stuffed 0, which does not consume a data bit.
  - Stuffing applies across byte boundaries and after the final data bit, before EOP.
  - The counter clears at `start_pkt`.
- **After EOP1:** `oe`=0 and the line returns to J.
- **Boundary conditions:**
  - `start_pkt` while `busy`=1 is ignored; no load and no `show_next`.
  - `rst` mid-packet: next cycle all outputs take reset values and the packet is abandoned; no EOP is sent.
  - `sbyte`/`last_pkt_byte` are sampled only at load cycles. Changes at any other time are ignored.

## Timing
- `start_pkt` sampled at edge 0. From edge 1: `oe`=1, `busy`=1, first bit on the line; each bit lasts exactly `CLK_DIV` cycles.
- `show_next` is asserted exactly 1 cycle after a load. The source must present the next byte within `CLK_DIV`-2 cycles.
- Packet duration with `oe`=1: (8·N + S + 3)·`CLK_DIV` cycles. N = bytes on the line; S = stuffed bits.
- `busy` falls in the same cycle as `oe`.

## Configuration
- `LS_USB_TX_CRC16_EN` defined:
  - A data packet is one whose byte 1 low nibble is 0x3 or 0xB (DATA0/DATA1).
  - For data packets, the block computes USB CRC16 over the unstuffed bits of bytes 2..last: poly x^16+x^15+x^2+1, init 0xFFFF, complemented.
  - It appends the two CRC bytes, LSB first, after the last source byte and before EOP. They are stuffed and NRZI-encoded like data.
  - Zero-length payload appends 0x00 0x00.
  - No `show_next` pulse occurs for CRC bytes.
- Not defined: bytes are sent verbatim and the source supplies any CRC.

## Test plan
- **ACK, CLK_DIV=8:** `start_pkt` with 0x80 then 0xD2 (last) → line K J K J K J K K, then NRZI of 0xD2. SE0 16 cycles, J 8 cycles. `oe` high 152 cycles; exactly 1 `show_next` pulse.
- **Stuffing:** 0x80 then 0xFF (last) → one stuffed 0 (a transition) after bit 4 of 0xFF. `oe` high 160 cycles.
- **CRC (macro on):** 0x80, 0x4B, 12 01 00 01 FF 00 00 08 (last) → bytes 0x23 0xF3 appended before EOP; 9 `show_next` pulses.
- **Empty data (macro on):** 0x80, 0x4B (last) → appends 0x00 0x00. `oe` high (32+3+S)·8 cycles.
- **Reset mid-packet:** `rst` during byte 1 → next cycle `oe`=0, `dp`=0, `dm`=1, `busy`=0. No SE0 appears.
- **Busy:** second `start_pkt` during DATA → ignored; first packet completes unchanged and `show_next` count is unchanged.

Source files
------------

// File: rtl/ls_usb_tx.sv
`default_nettype none
// ============================================================================
// Module      : ls_usb_tx
// Description : Low-speed USB packet transmitter. Pulls bytes from the packet
//               source, serializes LSB first, bit-stuffs, NRZI-encodes onto
//               D+/D- and closes every packet with SE0-SE0-J.
//               Optional macro LS_USB_TX_CRC16_EN appends CRC16 to DATA0/1.
// Revision    : 1.0 - initial release
// ============================================================================
module ls_usb_tx #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pkt,
    input  logic [7:0] sbyte,
    input  logic       last_pkt_byte,
    output logic       show_next,
    output logic       dp,
    output logic       dm,
    output logic       oe,
    output logic       busy
);

    localparam int c_CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_EOP0 = 2'd2,
        S_EOP1 = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_eop_bit;
    logic [7:0]         r_shift;
    logic               r_last;
    logic [2:0]         r_bitidx;
    logic [2:0]         r_ones;
    logic               r_level_k;
    logic               r_done;
    logic               r_sn_pend;
    logic               r_show_next;
    logic               r_dp;
    logic               r_dm;
    logic               r_oe;
    logic               r_busy;

    logic               w_accept;
    logic               w_boundary;
    logic               w_stuff;
    logic               w_bit;
    logic               w_level_k;
    logic [2:0]         w_ones_nxt;
    logic               w_byte_end;
    logic               w_final_byte;
    logic               w_pkt_end;

    // A new packet is only taken when fully idle, including the busy tail
    assign w_accept   = start_pkt && (r_state == S_IDLE) && !r_busy;
    assign w_boundary = (r_cnt == c_CNT_MAX);
    // Six ones in a row force a stuffed zero into the current slot
    assign w_stuff    = (r_ones == 3'd6);
    assign w_bit      = w_stuff ? 1'b0 : r_shift[0];
    // NRZI: a zero toggles the line, a one holds it
    assign w_level_k  = w_bit ? r_level_k : ~r_level_k;
    assign w_ones_nxt = w_bit ? (r_ones + 3'd1) : 3'd0;
    assign w_byte_end = !w_stuff && (r_bitidx == 3'd7);
    // The slot ends the packet unless a trailing stuff bit is still owed
    assign w_pkt_end  = r_done || (w_byte_end && w_final_byte && (w_ones_nxt != 3'd6));

`ifdef LS_USB_TX_CRC16_EN
    logic [1:0]  r_byte_num;
    logic        r_is_data;
    logic        r_crc_phase;
    logic [15:0] r_crc;
    logic [7:0]  r_crc_hi;
    logic [15:0] w_crc_upd;
    logic [15:0] w_crc_fin;

    // Reflected CRC16 (0x8005), only over payload bytes 2..last
    assign w_crc_upd = ((r_byte_num == 2'd2) && !r_crc_phase)
                     ? ({1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_bit) ? 16'hA001 : 16'h0000))
                     : r_crc;
    assign w_crc_fin = ~w_crc_upd;
    // For data packets the source's last byte is followed by two CRC bytes
    assign w_final_byte = r_last && !(r_is_data && !r_crc_phase);
`else
    assign w_final_byte = r_last;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, transitions happen only on bit boundaries
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                w_state_nxt = S_DATA;
            S_DATA:  if (w_boundary && w_pkt_end) w_state_nxt = S_EOP0;
            S_EOP0:  if (w_boundary && r_eop_bit) w_state_nxt = S_EOP1;
            S_EOP1:  if (w_boundary)              w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // Bit timer, shifter, stuffing counter, NRZI level and byte loading
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_eop_bit <= 1'b0;
            r_shift   <= 8'h00;
            r_last    <= 1'b0;
            r_bitidx  <= 3'd0;
            r_ones    <= 3'd0;
            r_level_k <= 1'b0;
            r_done    <= 1'b0;
            r_sn_pend <= 1'b0;
`ifdef LS_USB_TX_CRC16_EN
            r_byte_num  <= 2'd0;
            r_is_data   <= 1'b0;
            r_crc_phase <= 1'b0;
            r_crc       <= 16'hFFFF;
            r_crc_hi    <= 8'h00;
`endif
        end else begin
            r_sn_pend <= 1'b0;
            if (w_accept) begin
                r_cnt     <= '0;
                r_eop_bit <= 1'b0;
                r_shift   <= sbyte;
                r_last    <= last_pkt_byte;
                r_bitidx  <= 3'd0;
                r_ones    <= 3'd0;
                r_level_k <= 1'b0;
                r_done    <= 1'b0;
                r_sn_pend <= ~last_pkt_byte;
`ifdef LS_USB_TX_CRC16_EN
                r_byte_num  <= 2'd0;
                r_is_data   <= 1'b0;
                r_crc_phase <= 1'b0;
                r_crc       <= 16'hFFFF;
                r_crc_hi    <= 8'h00;
`endif
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_boundary ? '0 : (r_cnt + c_CNT_W'(1));
                if ((r_state == S_EOP0) && w_boundary) begin
                    r_eop_bit <= 1'b1;
                end
                if ((r_state == S_DATA) && w_boundary) begin
                    r_level_k <= w_level_k;
                    r_ones    <= w_ones_nxt;
                    if (!w_stuff) begin
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitidx <= r_bitidx + 3'd1;
`ifdef LS_USB_TX_CRC16_EN
                        r_crc    <= w_crc_upd;
`endif
                        if (r_bitidx == 3'd7) begin
                            if (w_final_byte) begin
                                r_done <= (w_ones_nxt == 3'd6);
`ifdef LS_USB_TX_CRC16_EN
                            end else if (r_crc_phase) begin
                                r_shift <= r_crc_hi;
                                r_last  <= 1'b1;
                            end else if (r_last) begin
                                r_shift     <= w_crc_fin[7:0];
                                r_crc_hi    <= w_crc_fin[15:8];
                                r_crc_phase <= 1'b1;
                                r_last      <= 1'b0;
`endif
                            end else begin
                                r_shift   <= sbyte;
                                r_last    <= last_pkt_byte;
                                r_sn_pend <= ~last_pkt_byte;
`ifdef LS_USB_TX_CRC16_EN
                                if (r_byte_num == 2'd0) begin
                                    r_is_data <= (sbyte[2:0] == 3'b011);
                                end
                                if (r_byte_num != 2'd2) begin
                                    r_byte_num <= r_byte_num + 2'd1;
                                end
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    // Line outputs, registered one cycle behind the internal state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp        <= 1'b0;
            r_dm        <= 1'b1;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_show_next <= 1'b0;
        end else begin
            r_show_next <= r_sn_pend;
            r_oe        <= (r_state != S_IDLE);
            r_busy      <= (r_state != S_IDLE);
            case (r_state)
                S_DATA: begin
                    r_dp <= w_level_k;
                    r_dm <= ~w_level_k;
                end
                S_EOP0: begin
                    r_dp <= 1'b0;
                    r_dm <= 1'b0;
                end
                default: begin
                    r_dp <= 1'b0;
                    r_dm <= 1'b1;
                end
            endcase
        end
    end

    assign show_next = r_show_next;
    assign dp        = r_dp;
    assign dm        = r_dm;
    assign oe        = r_oe;
    assign busy      = r_busy;

endmodule
`default_nettype wire
